// File: rtl/i2s_rx_capture.sv
// I2S record-path deserialiser: codec serial data -> signed stereo sample pairs, all on mclk.
// Latency: valid rises SYNC_STAGES+2 mclk after the raw BCLK rise carrying the right-channel LSB.
// Backpressure: output held while valid & !ready; a pair completing then is dropped and sets sticky overrun.
// Optional: I2S_RX_FRAME_CHECK_EN adds the slot-length check driving frame_err (pairs then release at the closing LRCLK fall).
module i2s_rx_capture #(
    parameter int SAMPLE_BITS = 16,
    parameter int SLOT_BITS   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   mclk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   audio_I2S_bclk,
    input  logic                   audio_I2S_reclrc,
    input  logic                   audio_I2S_recdat,
    output logic [SAMPLE_BITS-1:0] sample_left,
    output logic [SAMPLE_BITS-1:0] sample_right,
    output logic                   valid,
    input  logic                   ready,
    output logic                   overrun,
    input  logic                   overrun_clr,
    output logic                   frame_err
);

    // Counter must reach SLOT_BITS, so size it for SLOT_BITS+1 values.
    localparam int CNT_W = $clog2(SLOT_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_BITS);
    localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_ALIGN   = 2'd0;
    localparam logic [1:0] ST_SHIFT_L = 2'd1;
    localparam logic [1:0] ST_SHIFT_R = 2'd2;

    // ------------------------------------------------------------------
    // Input synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lrclk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   bclk_d;
    logic                   lrclk_d;
    logic                   bclk_s;
    logic                   lrclk_s;
    logic                   dat_s;
    logic                   bclk_rise;
    logic                   lrclk_rise;
    logic                   lrclk_fall;

    // Multi-stage synchronisers on the three asynchronous codec lines.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            bclk_sync  <= '0;
            lrclk_sync <= '0;
            dat_sync   <= '0;
        end else begin
            bclk_sync[0]  <= audio_I2S_bclk;
            lrclk_sync[0] <= audio_I2S_reclrc;
            dat_sync[0]   <= audio_I2S_recdat;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                bclk_sync[i]  <= bclk_sync[i-1];
                lrclk_sync[i] <= lrclk_sync[i-1];
                dat_sync[i]   <= dat_sync[i-1];
            end
        end
    end

    assign bclk_s  = bclk_sync[SYNC_STAGES-1];
    assign lrclk_s = lrclk_sync[SYNC_STAGES-1];
    assign dat_s   = dat_sync[SYNC_STAGES-1];

    // One extra register of the synchronised clocks for edge strobes.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            bclk_d  <= 1'b0;
            lrclk_d <= 1'b0;
        end else begin
            bclk_d  <= bclk_s;
            lrclk_d <= lrclk_s;
        end
    end

    // Data changes on BCLK falls, so dat_s is settled on the bclk_rise cycle.
    assign bclk_rise  = bclk_s & ~bclk_d;
    assign lrclk_rise = lrclk_s & ~lrclk_d;
    assign lrclk_fall = ~lrclk_s & lrclk_d;

    // ------------------------------------------------------------------
    // Frame tracking
    // ------------------------------------------------------------------
    logic [1:0]             state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [SAMPLE_BITS-1:0] shift_reg;
    logic [SAMPLE_BITS-1:0] shift_next;
    logic [SAMPLE_BITS-1:0] left_hold;
    logic                   left_ok;
    logic                   in_slot;
    logic                   lr_edge;
    logic                   shift_en;
    logic                   last_bit;
    logic                   left_done;
    logic                   right_done;
    logic                   slot_bad;

    // Per-cycle decode of which BCLK edge of the slot this is.
    always_comb begin
        in_slot    = enable && (state != ST_ALIGN);
        lr_edge    = lrclk_rise || lrclk_fall;
        shift_next = {shift_reg[SAMPLE_BITS-2:0], dat_s};
        // Edge 1 is the I2S delay bit; edges 2..SAMPLE_BITS+1 carry data.
        shift_en   = in_slot && bclk_rise && !lr_edge &&
                     (bit_cnt != '0) && (bit_cnt <= CNT_LAST);
        last_bit   = shift_en && (bit_cnt == CNT_LAST);
        left_done  = last_bit && (state == ST_SHIFT_L);
        // A right slot only completes a pair when its own left slot landed.
        right_done = last_bit && (state == ST_SHIFT_R) && left_ok;
    end

    // Slot alignment FSM; dropping enable always returns to ALIGN.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state <= ST_ALIGN;
        end else if (!enable) begin
            state <= ST_ALIGN;
        end else begin
            case (state)
                ST_ALIGN:   if (lrclk_fall) state <= ST_SHIFT_L;
                ST_SHIFT_L: if (lrclk_rise) state <= ST_SHIFT_R;
                ST_SHIFT_R: if (lrclk_fall) state <= ST_SHIFT_L;
                default:    state <= ST_ALIGN;
            endcase
        end
    end

    // BCLK counter within the current slot, cleared by each LRCLK edge.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (lr_edge) begin
            bit_cnt <= '0;
        end else if (bclk_rise && (bit_cnt != CNT_SLOT)) begin
            bit_cnt <= bit_cnt + CNT_ONE;
        end
    end

    // MSB-first shift register and left-channel holding register.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            left_hold <= '0;
        end else begin
            if (shift_en) begin
                shift_reg <= shift_next;
            end
            if (left_done) begin
                left_hold <= shift_next;
            end
        end
    end

    // Tracks whether left_hold belongs to the frame currently in progress.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            left_ok <= 1'b0;
        end else if (!in_slot || lrclk_fall) begin
            left_ok <= 1'b0;
        end else if (lrclk_rise && slot_bad) begin
            left_ok <= 1'b0;
        end else if (left_done) begin
            left_ok <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pair staging
    // ------------------------------------------------------------------
    logic [SAMPLE_BITS-1:0] pair_left;
    logic [SAMPLE_BITS-1:0] pair_right;
    logic                   pair_pend;

    // Snapshot of the finished pair, consumed by the output stage.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            pair_left  <= '0;
            pair_right <= '0;
        end else if (right_done) begin
            pair_left  <= left_hold;
            pair_right <= shift_next;
        end
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    logic right_ok;

    // A slot is short or long when its closing LRCLK edge sees a partial count.
    assign slot_bad = in_slot && lr_edge && (bit_cnt != CNT_SLOT);

    // Release the pair only once the closing LRCLK fall proves both slots full length.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            right_ok  <= 1'b0;
            pair_pend <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            pair_pend <= in_slot && lrclk_fall && (state == ST_SHIFT_R) &&
                         right_ok && !slot_bad;
            if (!in_slot || lr_edge) begin
                right_ok <= 1'b0;
            end else if (right_done) begin
                right_ok <= 1'b1;
            end
            if (slot_bad) begin
                frame_err <= 1'b1;
            end
        end
    end
`else
    assign slot_bad  = 1'b0;
    assign frame_err = 1'b0;

    // Offer the pair on the cycle after the right LSB is shifted in.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            pair_pend <= 1'b0;
        end else begin
            pair_pend <= right_done;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Output register and handshake
    // ------------------------------------------------------------------

    // Load when empty or draining this cycle; otherwise hold and drop the newcomer.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            sample_left  <= '0;
            sample_right <= '0;
            valid        <= 1'b0;
        end else if (pair_pend && (!valid || ready)) begin
            sample_left  <= pair_left;
            sample_right <= pair_right;
            valid        <= 1'b1;
        end else if (valid && ready) begin
            valid        <= 1'b0;
        end
    end

    // Sticky overrun; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (pair_pend && valid && !ready) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule
